// File: rtl/channel_accum_16_if.sv
// channel_accum_16_if: bus between the dot-channel stage / pixel controller
// and the channel accumulator.
//   master : drives start, num_phases, relu_en, bias, in_valid, din;
//            observes busy, out_valid, q
//   slave  : the accumulator side (mirror of master)
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

interface channel_accum_16_if;
    logic                        start;
    logic [2:0]                  num_phases;
    logic                        relu_en;
    logic signed [`DATA_LEN-1:0] bias;
    logic                        in_valid;
    logic signed [`DATA_LEN-1:0] din;
    logic                        busy;
    logic                        out_valid;
    logic signed [`DATA_LEN-1:0] q;

    modport master (
        output start, num_phases, relu_en, bias, in_valid, din,
        input  busy, out_valid, q
    );

    modport slave (
        input  start, num_phases, relu_en, bias, in_valid, din,
        output busy, out_valid, q
    );
endinterface

// File: rtl/channel_accum_16.sv
// channel_accum_16: sums the per-phase partial dot products of one output
// pixel at widened precision, adds a per-channel bias, optionally applies
// ReLU and saturates back to DATA_LEN. One result per pixel, flagged by a
// single-cycle out_valid pulse.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - channel_accum_16_if.slave (start/num_phases/relu_en/bias,
//          in_valid/din partial stream, busy/out_valid/q result)
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module channel_accum_16 #(
    parameter int ACC_EXT      = 4,
    parameter bit RELU_DEFAULT = 1'b1
) (
    input logic               clk,
    input logic               rst,
    channel_accum_16_if.slave bus
);
    localparam int DW = `DATA_LEN;
    localparam int AW = DW + ACC_EXT;

    localparam logic signed [AW-1:0] SAT_MAX = {{(ACC_EXT+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(ACC_EXT+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUT} state_t;

    state_t                 state_q, state_d;
    logic signed [AW-1:0]   acc_q, acc_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             n_q, n_d;
    logic signed [DW-1:0]   bias_q, bias_d;
    logic                   relu_q, relu_d;
    logic                   in_prev_q, in_prev_d;
    logic                   out_valid_q, out_valid_d;
    logic signed [DW-1:0]   q_q, q_d;

    logic                   rise;
    logic signed [AW-1:0]   din_ext, bias_ext, sum_biased, relu_val;
    logic signed [DW-1:0]   sat_val;

    // A partial counts only on the 0->1 transition; a held level is one partial.
    assign rise     = bus.in_valid & ~in_prev_q;
    assign din_ext  = {{ACC_EXT{bus.din[DW-1]}}, bus.din};
    assign bias_ext = {{ACC_EXT{bias_q[DW-1]}}, bias_q};

    // The final value is formed in BIAS so that q/out_valid come straight
    // from flops during the OUT cycle.
    assign sum_biased = acc_q + bias_ext;
    assign relu_val   = (relu_q && sum_biased[AW-1]) ? '0 : sum_biased;

    always_comb begin
        if (relu_val > SAT_MAX)
            sat_val = SAT_MAX[DW-1:0];
        else if (relu_val < SAT_MIN)
            sat_val = SAT_MIN[DW-1:0];
        else
            sat_val = relu_val[DW-1:0];
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        bias_d      = bias_q;
        relu_d      = relu_q;
        in_prev_d   = bus.in_valid;
        out_valid_d = 1'b0;
        q_d         = q_q;

        case (state_q)
            IDLE: begin
                // Edges here (including one coinciding with start) are ignored.
                if (bus.start) begin
                    n_d     = (bus.num_phases == 3'd0) ? 4'd8 : {1'b0, bus.num_phases};
                    bias_d  = bus.bias;
                    relu_d  = bus.relu_en;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (rise) begin
                    acc_d = acc_q + din_ext;
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == n_q)
                        state_d = BIAS;
                end
            end
            BIAS: begin
                acc_d       = sum_biased;
                q_d         = sat_val;
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            n_q         <= '0;
            bias_q      <= '0;
            relu_q      <= RELU_DEFAULT;
            in_prev_q   <= 1'b0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            bias_q      <= bias_d;
            relu_q      <= relu_d;
            in_prev_q   <= in_prev_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.q         = q_q;
endmodule

// File: tb/tb_channel_accum_16.sv
`ifndef DATA_LEN
`define DATA_LEN 16
`endif

module tb_channel_accum_16;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cmp = 0;
    int   err = 0;
    int   pulses = 0;
    int   consec = 0;
    logic prev_ov = 1'b0;

    channel_accum_16_if bus ();

    channel_accum_16 #(.ACC_EXT(4), .RELU_DEFAULT(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) pulses++;
        if (prev_ov === 1'b1 && bus.out_valid === 1'b1) consec++;
        prev_ov = bus.out_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int d, input int hold);
        bus.in_valid = 1'b1;
        bus.din      = 16'(d);
        repeat (hold) tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
    endtask

    // Last partial: no pulse right after its edge, pulse one cycle later.
    task automatic finish_check(input int d, input int exp, input string name);
        bus.in_valid = 1'b1;
        bus.din      = 16'(d);
        tick();
        cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            err++;
            $display("FAIL %s early: out_valid=%b busy=%b want 0/1", name, bus.out_valid, bus.busy);
        end
        tick();
        cmp++;
        if (bus.out_valid !== 1'b1) begin
            err++;
            $display("FAIL %s latency: out_valid=%b want 1", name, bus.out_valid);
        end
        cmp++;
        if (bus.q !== 16'(exp)) begin
            err++;
            $display("FAIL %s q: got %0d want %0d", name, $signed(bus.q), exp);
        end
    endtask

    task automatic run_pixel(input logic [2:0] n, input int b, input logic r,
                             input int p[8], input int cnt, input int hold,
                             input int exp, input string name);
        int p0;
        p0 = pulses;
        bus.start      = 1'b1;
        bus.num_phases = n;
        bus.bias       = 16'(b);
        bus.relu_en    = r;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < cnt - 1; i++) feed(p[i], hold);
        finish_check(p[cnt-1], exp, name);
        tick();
        bus.in_valid = 1'b0;
        cmp++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            err++;
            $display("FAIL %s after: out_valid=%b busy=%b want 0/0", name, bus.out_valid, bus.busy);
        end
        cmp++;
        if (pulses - p0 != 1) begin
            err++;
            $display("FAIL %s pulses: got %0d want 1", name, pulses - p0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        cmp++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.q !== 16'd0) begin
            err++;
            $display("FAIL reset: busy=%b out_valid=%b q=%0d want 0/0/0", bus.busy, bus.out_valid, bus.q);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int p[8] = '{100, -20, 5, 0, 0, 0, 0, 0};
        run_pixel(3'd3, 10, 1'b0, p, 3, 4, 95, "basic");
    endtask

    task automatic test_relu();
        int p[8] = '{10, 20, 0, 0, 0, 0, 0, 0};
        run_pixel(3'd2, -50, 1'b1, p, 2, 2, 0, "relu_on");
        run_pixel(3'd2, -50, 1'b0, p, 2, 2, -20, "relu_off");
    endtask

    task automatic test_saturation();
        int pp[8] = '{30000, 30000, 30000, 30000, 30000, 30000, 30000, 30000};
        int pn[8] = '{-30000, -30000, -30000, -30000, -30000, -30000, -30000, -30000};
        run_pixel(3'd0, 0, 1'b0, pp, 8, 1, 32767, "sat_pos");
        run_pixel(3'd0, -1000, 1'b0, pn, 8, 1, -32768, "sat_neg");
    endtask

    task automatic test_edges();
        int p0;
        p0 = pulses;
        // Edge coinciding with start must not count, nor its held level.
        bus.start      = 1'b1;
        bus.num_phases = 3'd2;
        bus.bias       = 16'd3;
        bus.relu_en    = 1'b0;
        bus.in_valid   = 1'b1;
        bus.din        = 16'd999;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        tick();
        // Ignored second start with different N and bias.
        bus.start      = 1'b1;
        bus.num_phases = 3'd1;
        bus.bias       = 16'd100;
        tick();
        bus.start = 1'b0;
        feed(4, 2);
        cmp++;
        if (bus.busy !== 1'b1 || pulses != p0) begin
            err++;
            $display("FAIL edges mid: busy=%b pulses=%0d want 1/%0d", bus.busy, pulses, p0);
        end
        finish_check(5, 12, "edges");
        tick();
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midop();
        int p[8] = '{7, 0, 0, 0, 0, 0, 0, 0};
        int p0;
        p0 = pulses;
        bus.start      = 1'b1;
        bus.num_phases = 3'd4;
        bus.bias       = 16'd0;
        bus.relu_en    = 1'b0;
        tick();
        bus.start = 1'b0;
        feed(11, 2);
        feed(22, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cmp++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.q !== 16'd0) begin
            err++;
            $display("FAIL reset_midop: busy=%b out_valid=%b q=%0d want 0/0/0", bus.busy, bus.out_valid, bus.q);
        end
        cmp++;
        if (pulses != p0) begin
            err++;
            $display("FAIL reset_midop pulses: got %0d want %0d", pulses, p0);
        end
        run_pixel(3'd1, 0, 1'b0, p, 1, 2, 7, "after_reset");
    endtask

    task automatic test_back_to_back();
        int pa[8] = '{1, 2, 0, 0, 0, 0, 0, 0};
        int pb[8] = '{-3, 40, -5, 0, 0, 0, 0, 0};
        int c0;
        c0 = consec;
        run_pixel(3'd2, 0, 1'b0, pa, 2, 1, 3, "b2b_a");
        run_pixel(3'd3, 1, 1'b1, pb, 3, 1, 33, "b2b_b");
        cmp++;
        if (consec != c0) begin
            err++;
            $display("FAIL b2b spacing: consecutive pulses=%0d want 0", consec - c0);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.num_phases = 3'd0;
        bus.relu_en    = 1'b0;
        bus.bias       = '0;
        bus.in_valid   = 1'b0;
        bus.din        = '0;
        test_reset();
        test_basic();
        test_relu();
        test_saturation();
        test_edges();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule
